// File: rtl/oq_enqueue_agent_if.sv
// Purpose: stream/queue bundle between the enqueue agent and its neighbours.
// Carries the upstream AXI4-Stream slave side (s_axis_*), the beat stream
// toward the output queue write port (m_axis_*, buffer_wr_en, pifo_insert_en,
// tpifo) and the queue's full flags (s_is_*).
// Modports: master = the enqueue agent, slave = upstream source plus queue.
interface oq_enqueue_agent_if #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_PIFO_WIDTH       = 32
);
    localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;

    logic                          s_axis_tvalid;
    logic                          s_axis_tready;
    logic                          s_axis_tlast;
    logic [C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
    logic [KEEP_W-1:0]             s_axis_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser;

    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata;
    logic [KEEP_W-1:0]             m_axis_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
    logic [C_PIFO_WIDTH-1:0]       m_axis_tpifo;
    logic                          m_axis_buffer_wr_en;
    logic                          m_axis_pifo_insert_en;

    logic                          s_is_buffer_almost_full;
    logic                          s_is_pifo_full;

    modport master (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, s_axis_tuser,
        input  s_is_buffer_almost_full, s_is_pifo_full,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        output m_axis_tpifo, m_axis_buffer_wr_en, m_axis_pifo_insert_en
    );

    modport slave (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, s_axis_tuser,
        output s_is_buffer_almost_full, s_is_pifo_full,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        input  m_axis_tpifo, m_axis_buffer_wr_en, m_axis_pifo_insert_en
    );
endinterface

// File: rtl/oq_enqueue_agent.sv
// Purpose: write-side front end of the output queue. Takes an AXI4-Stream
// packet stream, decides admit/drop/stall once per packet at its head beat
// from the queue full flags, tags admitted packets with {seq, rank} and
// forwards beats one cycle later as buffer writes plus a head PIFO insert.
// Ports:
//   axis_aclk, axis_resetn : clock, asynchronous active-low reset
//   bus (master)           : s_axis_* in, m_axis_* out, queue full flags in
//   drop_count             : packets dropped at head, saturating
//   pkt_count              : packets admitted, wrapping
// SEQ_RESET is the sequence number loaded at reset (0 in normal use).
module oq_enqueue_agent #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_PIFO_WIDTH       = 32,
    parameter int unsigned RANK_LSB           = 64,
    parameter bit          DROP_ON_FULL       = 1'b1,
    parameter logic [15:0] SEQ_RESET          = 16'h0000
) (
    input  logic               axis_aclk,
    input  logic               axis_resetn,
    oq_enqueue_agent_if.master bus,
    output logic [31:0]        drop_count,
    output logic [31:0]        pkt_count
);
    localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned RANK_W = 16;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                        r_state;
    logic [SEQ_W-1:0]              r_seq;
    logic [CNT_W-1:0]              r_drop_count;
    logic [CNT_W-1:0]              r_pkt_count;
    logic                          r_m_tvalid;
    logic                          r_m_tlast;
    logic                          r_wr_en;
    logic                          r_ins_en;
    logic [C_AXIS_DATA_WIDTH-1:0]  r_m_tdata;
    logic [KEEP_W-1:0]             r_m_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0] r_m_tuser;
    logic [C_PIFO_WIDTH-1:0]       r_m_tpifo;

    logic              w_full;
    logic              w_tready;
    logic              w_hs;
    logic              w_head_admit;
    logic              w_fwd;
    logic [RANK_W-1:0] w_rank;

    assign w_full = bus.s_is_buffer_almost_full | bus.s_is_pifo_full;
    assign w_rank = bus.s_axis_tuser[RANK_LSB +: RANK_W];

    // Only a head beat can be held back, and only when stalling is chosen over dropping.
    always_comb begin
        w_tready = 1'b0;
        if (axis_resetn) begin
            if (r_state == ST_HEAD) begin
                w_tready = ~(w_full & ~DROP_ON_FULL);
            end else begin
                w_tready = 1'b1;
            end
        end
    end

    assign w_hs         = bus.s_axis_tvalid & w_tready;
    assign w_head_admit = w_hs & (r_state == ST_HEAD) & ~w_full;
    assign w_fwd        = w_head_admit | (w_hs & (r_state == ST_FWD));

    // Packet state machine with registered output beat.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state      <= ST_HEAD;
            r_seq        <= SEQ_RESET;
            r_drop_count <= '0;
            r_pkt_count  <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_ins_en     <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tuser    <= '0;
            r_m_tpifo    <= '0;
        end else begin
            r_m_tvalid <= w_fwd;
            r_wr_en    <= w_fwd;
            r_m_tlast  <= w_fwd & bus.s_axis_tlast;
            r_ins_en   <= w_head_admit;
            r_m_tpifo  <= '0;

            // Payload registers hold between beats.
            if (w_fwd) begin
                r_m_tdata <= bus.s_axis_tdata;
                r_m_tkeep <= bus.s_axis_tkeep;
                r_m_tuser <= bus.s_axis_tuser;
            end

            if (w_head_admit) begin
                r_m_tpifo   <= C_PIFO_WIDTH'({r_seq, w_rank});
                r_seq       <= r_seq + 16'd1;
                r_pkt_count <= r_pkt_count + 32'd1;
            end

            if (w_hs) begin
                case (r_state)
                    ST_HEAD: begin
                        if (w_full) begin
                            // Reachable only when dropping; stalling keeps tready low.
                            if (r_drop_count != {CNT_W{1'b1}}) begin
                                r_drop_count <= r_drop_count + 32'd1;
                            end
                            r_state <= bus.s_axis_tlast ? ST_HEAD : ST_DROP;
                        end else begin
                            r_state <= bus.s_axis_tlast ? ST_HEAD : ST_FWD;
                        end
                    end
                    ST_FWD:  if (bus.s_axis_tlast) r_state <= ST_HEAD;
                    ST_DROP: if (bus.s_axis_tlast) r_state <= ST_HEAD;
                    default: r_state <= ST_HEAD;
                endcase
            end
        end
    end

    assign bus.s_axis_tready         = w_tready;
    assign bus.m_axis_tvalid         = r_m_tvalid;
    assign bus.m_axis_tlast          = r_m_tlast;
    assign bus.m_axis_tdata          = r_m_tdata;
    assign bus.m_axis_tkeep          = r_m_tkeep;
    assign bus.m_axis_tuser          = r_m_tuser;
    assign bus.m_axis_tpifo          = r_m_tpifo;
    assign bus.m_axis_buffer_wr_en   = r_wr_en;
    assign bus.m_axis_pifo_insert_en = r_ins_en;
    assign drop_count                = r_drop_count;
    assign pkt_count                 = r_pkt_count;
endmodule

// File: tb/tb_oq_enqueue_agent.sv
// Bench for oq_enqueue_agent. Unit 0 drops on full (seq from 0), unit 1
// stalls on full (seq from 0xFFFF). A packet-level model predicts each cycle.
module tb_oq_enqueue_agent;
    localparam int unsigned DW       = 256;
    localparam int unsigned UW       = 128;
    localparam int unsigned KW       = DW / 8;
    localparam int unsigned RANK_LSB = 64;
    localparam int          NU       = 2;

    logic clk;
    logic rst_n;

    logic          tv [NU];
    logic          tl [NU];
    logic          af [NU];
    logic          pf [NU];
    logic [DW-1:0] td [NU];
    logic [KW-1:0] tk [NU];
    logic [UW-1:0] tu [NU];

    logic          o_rdy [NU];
    logic          o_tv  [NU];
    logic          o_tl  [NU];
    logic          o_wr  [NU];
    logic          o_ins [NU];
    logic [31:0]   o_tp  [NU];
    logic [DW-1:0] o_td  [NU];
    logic [KW-1:0] o_tk  [NU];
    logic [UW-1:0] o_tu  [NU];
    logic [31:0]   o_dc  [NU];
    logic [31:0]   o_pc  [NU];

    for (genvar g = 0; g < NU; g++) begin : gu
        oq_enqueue_agent_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_PIFO_WIDTH(32)) bus ();
        assign bus.s_axis_tvalid           = tv[g];
        assign bus.s_axis_tlast            = tl[g];
        assign bus.s_axis_tdata            = td[g];
        assign bus.s_axis_tkeep            = tk[g];
        assign bus.s_axis_tuser            = tu[g];
        assign bus.s_is_buffer_almost_full = af[g];
        assign bus.s_is_pifo_full          = pf[g];
        assign o_rdy[g] = bus.s_axis_tready;
        assign o_tv[g]  = bus.m_axis_tvalid;
        assign o_tl[g]  = bus.m_axis_tlast;
        assign o_wr[g]  = bus.m_axis_buffer_wr_en;
        assign o_ins[g] = bus.m_axis_pifo_insert_en;
        assign o_tp[g]  = bus.m_axis_tpifo;
        assign o_td[g]  = bus.m_axis_tdata;
        assign o_tk[g]  = bus.m_axis_tkeep;
        assign o_tu[g]  = bus.m_axis_tuser;

        oq_enqueue_agent #(
            .C_AXIS_DATA_WIDTH (DW),
            .C_AXIS_TUSER_WIDTH(UW),
            .C_PIFO_WIDTH      (32),
            .RANK_LSB          (RANK_LSB),
            .DROP_ON_FULL      (g == 0),
            .SEQ_RESET         (g == 0 ? 16'h0000 : 16'hFFFF)
        ) dut (
            .axis_aclk  (clk),
            .axis_resetn(rst_n),
            .bus        (bus),
            .drop_count (o_dc[g]),
            .pkt_count  (o_pc[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: packet-level view of each unit.
    bit            m_in_pkt [NU];
    bit            m_adm    [NU];
    int unsigned   m_seq    [NU];
    int unsigned   m_pkts   [NU];
    int unsigned   m_drops  [NU];
    logic          e_tv [NU];
    logic          e_tl [NU];
    logic          e_wr [NU];
    logic          e_ins[NU];
    logic [31:0]   e_tp [NU];
    logic [DW-1:0] e_td [NU];
    logic [KW-1:0] e_tk [NU];
    logic [UW-1:0] e_tu [NU];

    int checks;
    int errors;

    function automatic bit dof(input int u);
        return u == 0;
    endfunction

    task automatic chk(input string tag, input int u, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL u%0d %s: observed %0h expected %0h", u, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            m_in_pkt[u] = 1'b0;
            m_adm[u]    = 1'b0;
            m_seq[u]    = (u == 0) ? 32'd0 : 32'd65535;
            m_pkts[u]   = 0;
            m_drops[u]  = 0;
            e_tv[u] = 1'b0; e_tl[u] = 1'b0; e_wr[u] = 1'b0; e_ins[u] = 1'b0;
            e_tp[u] = '0;   e_td[u] = '0;   e_tk[u] = '0;   e_tu[u]  = '0;
        end
    endtask

    task automatic chk_reset_all();
        for (int u = 0; u < NU; u++) begin
            chk("rst tready", u, DW'(o_rdy[u]), '0);
            chk("rst tvalid", u, DW'(o_tv[u]), '0);
            chk("rst tlast", u, DW'(o_tl[u]), '0);
            chk("rst wr_en", u, DW'(o_wr[u]), '0);
            chk("rst insert_en", u, DW'(o_ins[u]), '0);
            chk("rst tpifo", u, DW'(o_tp[u]), '0);
            chk("rst tdata", u, o_td[u], '0);
            chk("rst tkeep", u, DW'(o_tk[u]), '0);
            chk("rst tuser", u, DW'(o_tu[u]), '0);
            chk("rst drop_count", u, DW'(o_dc[u]), '0);
            chk("rst pkt_count", u, DW'(o_pc[u]), '0);
        end
    endtask

    // One clock of unit u: predict from current inputs, then compare after the edge.
    task automatic step(input int u, output bit hs);
        bit full;
        bit rdy;
        #1;
        full = (af[u] | pf[u]) === 1'b1;
        rdy  = m_in_pkt[u] ? 1'b1 : !(full && !dof(u));
        chk("tready", u, DW'(o_rdy[u]), DW'(rdy));
        hs = (tv[u] === 1'b1) && rdy;
        e_tv[u] = 1'b0; e_tl[u] = 1'b0; e_wr[u] = 1'b0; e_ins[u] = 1'b0; e_tp[u] = '0;
        if (hs) begin
            if (!m_in_pkt[u]) begin
                m_adm[u] = !full;
                if (full) begin
                    if (m_drops[u] != 32'hFFFF_FFFF) m_drops[u]++;
                end else begin
                    e_ins[u] = 1'b1;
                    e_tp[u]  = {16'(m_seq[u]), tu[u][RANK_LSB +: 16]};
                    m_seq[u] = (m_seq[u] + 1) % 65536;
                    m_pkts[u]++;
                end
            end
            if (m_adm[u]) begin
                e_tv[u] = 1'b1; e_wr[u] = 1'b1; e_tl[u] = tl[u];
                e_td[u] = td[u]; e_tk[u] = tk[u]; e_tu[u] = tu[u];
            end
            m_in_pkt[u] = !tl[u];
        end
        @(posedge clk);
        #1;
        chk("m_axis_tvalid", u, DW'(o_tv[u]), DW'(e_tv[u]));
        chk("buffer_wr_en", u, DW'(o_wr[u]), DW'(e_wr[u]));
        chk("pifo_insert_en", u, DW'(o_ins[u]), DW'(e_ins[u]));
        chk("tpifo", u, DW'(o_tp[u]), DW'(e_tp[u]));
        chk("tdata", u, o_td[u], e_td[u]);
        chk("tkeep", u, DW'(o_tk[u]), DW'(e_tk[u]));
        chk("tuser", u, DW'(o_tu[u]), DW'(e_tu[u]));
        chk("drop_count", u, DW'(o_dc[u]), DW'(m_drops[u]));
        chk("pkt_count", u, DW'(o_pc[u]), DW'(m_pkts[u]));
        if (e_tv[u]) chk("tlast", u, DW'(o_tl[u]), DW'(e_tl[u]));
    endtask

    task automatic set_beat(input int u, input bit last, input logic [15:0] rank);
        tv[u] = 1'b1;
        tl[u] = last;
        for (int k = 0; k < int'(DW / 32); k++) td[u][k*32 +: 32] = $urandom();
        tk[u] = KW'($urandom());
        for (int k = 0; k < int'(UW / 32); k++) tu[u][k*32 +: 32] = $urandom();
        tu[u][RANK_LSB +: 16] = rank;
    endtask

    task automatic send_pkt(input int u, input int n, input logic [15:0] rank, input bit rflags);
        for (int i = 0; i < n; i++) begin
            bit hs;
            int guard;
            set_beat(u, i == n - 1, rank);
            hs    = 1'b0;
            guard = 0;
            while (!hs) begin
                if (rflags) begin
                    af[u] = ($urandom_range(0, 3) == 0);
                    pf[u] = ($urandom_range(0, 5) == 0);
                end
                step(u, hs);
                guard++;
                if (!hs && guard >= 64) begin
                    checks++;
                    errors++;
                    $display("FAIL u%0d handshake timeout: observed no accept expected accept within 64 cycles", u);
                    break;
                end
            end
        end
        tv[u] = 1'b0;
        tl[u] = 1'b0;
    endtask

    task automatic idle(input int u, input int n);
        bit hs;
        tv[u] = 1'b0;
        for (int i = 0; i < n; i++) step(u, hs);
    endtask

    initial begin
        bit hs;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int u = 0; u < NU; u++) begin
            tv[u] = 1'b0; tl[u] = 1'b0; af[u] = 1'b0; pf[u] = 1'b0;
            td[u] = '0;   tk[u] = '0;   tu[u] = '0;
        end
        model_reset();
        #12;
        chk_reset_all();
        rst_n = 1'b1;

        // Drop a 4-beat packet whose head sees pifo full.
        pf[0] = 1'b1;
        send_pkt(0, 4, 16'h0011, 1'b0);
        pf[0] = 1'b0;
        chk("drop_count after drop", 0, DW'(o_dc[0]), DW'(32'd1));

        // Admit a 3-beat packet with rank 0x0042; seq still 0.
        send_pkt(0, 3, 16'h0042, 1'b0);
        idle(0, 1);
        chk("pkt_count after admit", 0, DW'(o_pc[0]), DW'(32'd1));

        // almost_full rising mid-packet does not affect it; next head is dropped.
        for (int i = 0; i < 4; i++) begin
            if (i == 1) af[0] = 1'b1;
            set_beat(0, i == 3, 16'h0007);
            step(0, hs);
        end
        tv[0] = 1'b0;
        send_pkt(0, 2, 16'h0008, 1'b0);
        af[0] = 1'b0;
        idle(0, 1);
        chk("drop_count after mid rise", 0, DW'(o_dc[0]), DW'(32'd2));

        // Randomized traffic with random full flags, drop mode.
        for (int p = 0; p < 30; p++) begin
            send_pkt(0, $urandom_range(1, 4), 16'($urandom()), 1'b1);
            af[0] = 1'b0; pf[0] = 1'b0;
            idle(0, $urandom_range(0, 2));
        end

        // Back-to-back single-beat packets across the seq wrap (unit 1 starts at 0xFFFF).
        send_pkt(1, 1, 16'hAAAA, 1'b0);
        send_pkt(1, 1, 16'h5555, 1'b0);
        idle(1, 1);

        // Stall: almost_full held 5 cycles at the head, then released.
        af[1] = 1'b1;
        set_beat(1, 1'b0, 16'h0033);
        for (int i = 0; i < 5; i++) step(1, hs);
        af[1] = 1'b0;
        step(1, hs);
        set_beat(1, 1'b0, 16'h0033);
        step(1, hs);
        set_beat(1, 1'b1, 16'h0033);
        step(1, hs);
        idle(1, 1);
        chk("drop_count stall mode", 1, DW'(o_dc[1]), '0);

        // Randomized traffic with random full flags, stall mode.
        for (int p = 0; p < 30; p++) begin
            send_pkt(1, $urandom_range(1, 4), 16'($urandom()), 1'b1);
            af[1] = 1'b0; pf[1] = 1'b0;
            idle(1, $urandom_range(0, 2));
        end

        // Reset during beat 2 of a packet.
        set_beat(0, 1'b0, 16'h0099);
        step(0, hs);
        set_beat(0, 1'b0, 16'h0099);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_all();
        model_reset();
        tv[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_pkt(0, 1, 16'h0042, 1'b0);
        idle(0, 1);
        send_pkt(1, 1, 16'h0001, 1'b0);
        idle(1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
